btb_update_unit: RTL and testbench

Branch-resolution side of the branch target buffer. Takes each resolved branch from the execute stage, computes the next 2-bit saturating prediction state, flags mispredictions with a redirect PC for fetch, and queues BTB writes, draining one per cycle onto the BTB write port (`we` / `Address2` / `BranchAddress` / `FSMResult`). It is the writer counterpart to the fetch-stage BTB lookup.

---
 rtl/btb_pkg.sv | 32 +++
 rtl/btb_update_queue.sv | 76 +++++++
 rtl/btb_update_unit.sv | 119 +++++++++++
 tb/tb_btb_update_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared definitions for the BTB update path: 2-bit counter encoding,
// queued-entry layout and the saturating counter update.
package btb_pkg;

  localparam logic [1:0] SNT = 2'b00;  // strong not-taken
  localparam logic [1:0] WNT = 2'b01;  // weak not-taken
  localparam logic [1:0] WT  = 2'b10;  // weak taken
  localparam logic [1:0] ST  = 2'b11;  // strong taken

  // State written when a taken branch with no BTB entry is allocated.
  localparam logic [1:0] ALLOC_STATE = WT;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic [1:0]  state;
  } btb_entry_t;

  // Saturating 2-bit counter: taken counts up to ST, not-taken down to SNT.
  function automatic logic [1:0] next_state(input logic [1:0] state, input logic taken);
    logic [1:0] result;
    if (taken) begin
      if (state == ST) result = ST;
      else             result = state + 2'd1;
    end else begin
      if (state == SNT) result = SNT;
      else              result = state - 2'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/btb_update_queue.sv
// FIFO of pending BTB writes. Besides the usual head view it exposes every
// entry's PC and state in age order (index 0 = oldest) with valid bits so
// the top level can find the youngest queued write for a given PC.
module btb_update_queue
  import btb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       push,
  input  btb_entry_t push_entry,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output btb_entry_t out_entry,
  output logic [31:0] entry_pc [DEPTH],
  output logic [1:0]  entry_state [DEPTH],
  output logic [DEPTH-1:0] entry_valid
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  btb_entry_t     mem_r [DEPTH];
  btb_entry_t     hold_r;
  logic [PW-1:0]  rd_ptr_r;
  logic [PW-1:0]  wr_ptr_r;
  logic [PW:0]    count_r;
  logic           do_push_s;
  logic           do_pop_s;

  assign full      = (count_r == FULL_COUNT);
  assign empty     = (count_r == '0);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Write port shows the head, or the last popped entry once drained.
  assign out_entry = empty ? hold_r : mem_r[rd_ptr_r];

  // Pointer, occupancy and last-popped bookkeeping; pointers wrap at DEPTH.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      hold_r   <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
        hold_r   <= mem_r[rd_ptr_r];
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only observed through valid bits or the head.
  always_ff @(posedge Clk) begin
    if (Rst_n && do_push_s) mem_r[wr_ptr_r] <= push_entry;
  end

  // Age-ordered view of the queue for the forwarding search.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_pc[i]    = mem_r[rd_ptr_r + PW'(i)].pc;
      entry_state[i] = mem_r[rd_ptr_r + PW'(i)].state;
      entry_valid[i] = ((PW+1)'(i) < count_r);
    end
  end

endmodule

// File: rtl/btb_update_unit.sv
// Branch-resolution side of the BTB: computes the next prediction state of
// each resolved branch, raises a one-cycle mispredict flush with the correct
// PC, and queues BTB writes that drain one per cycle onto the write port.
module btb_update_unit
  import btb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        ExValid,
  output logic        ExReady,
  input  logic [31:0] ExPC,
  input  logic [31:0] ExTarget,
  input  logic        ExTaken,
  input  logic        ExHit,
  input  logic [1:0]  ExState,
  input  logic [31:0] ExPredTarget,
  input  logic        BtbBusy,
  output logic        we,
  output logic [31:0] Address2,
  output logic [31:0] BranchAddress,
  output logic [1:0]  FSMResult,
  output logic        Flush,
  output logic [31:0] RedirectPC
);

  logic               full_s;
  logic               empty_s;
  btb_entry_t         out_entry_s;
  btb_entry_t         push_entry_s;
  logic [31:0]        entry_pc_s [DEPTH];
  logic [1:0]         entry_state_s [DEPTH];
  logic [DEPTH-1:0]   entry_valid_s;

  logic               accept_s;
  logic               fwd_hit_s;
  logic [1:0]         fwd_state_s;
  logic               pred_taken_s;
  logic               has_entry_s;
  logic [1:0]         new_state_s;
  logic               push_s;
  logic               mispredict_s;
  logic [31:0]        redirect_s;
  logic               flush_r;
  logic [31:0]        redirect_pc_r;

  assign ExReady  = !full_s;
  assign accept_s = ExValid && !full_s;
  assign we       = !empty_s && !BtbBusy;

  btb_update_queue #(.DEPTH(DEPTH)) u_queue (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .push        (push_s),
    .push_entry  (push_entry_s),
    .pop         (we),
    .full        (full_s),
    .empty       (empty_s),
    .out_entry   (out_entry_s),
    .entry_pc    (entry_pc_s),
    .entry_state (entry_state_s),
    .entry_valid (entry_valid_s)
  );

  // Youngest queued write to the same PC wins; scanning oldest to youngest
  // lets later matches overwrite earlier ones.
  always_comb begin
    fwd_hit_s   = 1'b0;
    fwd_state_s = SNT;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid_s[i] && (entry_pc_s[i] == ExPC)) begin
        fwd_hit_s   = 1'b1;
        fwd_state_s = entry_state_s[i];
      end else begin
        fwd_hit_s   = fwd_hit_s;
        fwd_state_s = fwd_state_s;
      end
    end
  end

  // Next-state, enqueue decision and mispredict detection for the branch.
  // Prediction uses only fetch-time values; forwarding only affects the update.
  always_comb begin
    pred_taken_s = ExHit && ExState[1];
    has_entry_s  = fwd_hit_s || ExHit;
    new_state_s  = ALLOC_STATE;
    if (fwd_hit_s) begin
      new_state_s = next_state(fwd_state_s, ExTaken);
    end else if (ExHit) begin
      new_state_s = next_state(ExState, ExTaken);
    end else begin
      new_state_s = ALLOC_STATE;
    end
    push_s       = accept_s && (has_entry_s || ExTaken);
    push_entry_s = '{pc: ExPC, target: ExTarget, state: new_state_s};
    mispredict_s = (pred_taken_s != ExTaken) ||
                   (pred_taken_s && ExTaken && (ExPredTarget != ExTarget));
    redirect_s   = ExTaken ? ExTarget : (ExPC + 32'd4);
  end

  // One-cycle flush pulse per accepted mispredicting branch, with its PC.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      flush_r       <= 1'b0;
      redirect_pc_r <= 32'd0;
    end else begin
      flush_r <= accept_s && mispredict_s;
      if (accept_s && mispredict_s) redirect_pc_r <= redirect_s;
    end
  end

  assign Flush         = flush_r;
  assign RedirectPC    = redirect_pc_r;
  assign Address2      = out_entry_s.pc;
  assign BranchAddress = out_entry_s.target;
  assign FSMResult     = out_entry_s.state;

endmodule

// File: tb/tb_btb_update_unit.sv
// Self-checking bench for btb_update_unit: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based behavioural model.
module tb_btb_update_unit;

  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        ExValid;
  logic        ExReady;
  logic [31:0] ExPC;
  logic [31:0] ExTarget;
  logic        ExTaken;
  logic        ExHit;
  logic [1:0]  ExState;
  logic [31:0] ExPredTarget;
  logic        BtbBusy;
  logic        we;
  logic [31:0] Address2;
  logic [31:0] BranchAddress;
  logic [1:0]  FSMResult;
  logic        Flush;
  logic [31:0] RedirectPC;

  always #5 Clk = ~Clk;

  btb_update_unit #(.DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .ExValid(ExValid), .ExReady(ExReady),
    .ExPC(ExPC), .ExTarget(ExTarget), .ExTaken(ExTaken), .ExHit(ExHit),
    .ExState(ExState), .ExPredTarget(ExPredTarget), .BtbBusy(BtbBusy),
    .we(we), .Address2(Address2), .BranchAddress(BranchAddress),
    .FSMResult(FSMResult), .Flush(Flush), .RedirectPC(RedirectPC)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [1:0]  st;
  } ent_t;

  int   checks   = 0;
  int   failures = 0;
  bit   chk_en   = 1'b0;

  // Behavioural model state
  ent_t        q[$];
  ent_t        m_last;
  logic        m_flush;
  logic [31:0] m_redir;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] sat(input logic [1:0] s, input logic taken);
    int v;
    v = int'(s) + (taken ? 1 : -1);
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return 2'(v);
  endfunction

  // Compare every observable output against the model.
  task automatic model_check();
    logic        exp_we;
    ent_t        shown;
    if (!chk_en) return;
    exp_we = (q.size() > 0) && !BtbBusy;
    shown  = (q.size() > 0) ? q[0] : m_last;
    cmp("m_we",       32'(we),       32'(exp_we));
    cmp("m_ready",    32'(ExReady),  32'(q.size() < DEPTH));
    cmp("m_addr2",    Address2,      shown.pc);
    cmp("m_baddr",    BranchAddress, shown.tgt);
    cmp("m_fsm",      32'(FSMResult), 32'(shown.st));
    cmp("m_flush",    32'(Flush),    32'(m_flush));
    if (m_flush) cmp("m_redirect", RedirectPC, m_redir);
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic model_update();
    logic acc, pop, found, pred, mis, push;
    logic [1:0] base;
    ent_t e;
    if (!Rst_n) begin
      q.delete();
      m_last  = '{pc: 32'd0, tgt: 32'd0, st: 2'd0};
      m_flush = 1'b0;
      m_redir = 32'd0;
      return;
    end
    acc     = ExValid && (q.size() < DEPTH);
    pop     = (q.size() > 0) && !BtbBusy;
    push    = 1'b0;
    m_flush = 1'b0;
    if (acc) begin
      found = 1'b0;
      base  = 2'd0;
      foreach (q[i]) if (q[i].pc == ExPC) begin found = 1'b1; base = q[i].st; end
      if (!found && ExHit) begin found = 1'b1; base = ExState; end
      pred = ExHit && ExState[1];
      mis  = (pred != ExTaken) || (pred && ExTaken && (ExPredTarget != ExTarget));
      if (mis) begin
        m_flush = 1'b1;
        m_redir = ExTaken ? ExTarget : ExPC + 32'd4;
      end
      if (found || ExTaken) begin
        push = 1'b1;
        e = '{pc: ExPC, tgt: ExTarget, st: (found ? sat(base, ExTaken) : 2'b10)};
      end
    end
    if (pop) begin
      m_last = q[0];
      void'(q.pop_front());
    end
    if (push) q.push_back(e);
  endtask

  // Drive one cycle: inputs set after the falling edge, outputs checked,
  // model advanced, then wait through the rising edge to the next falling edge.
  task automatic step(input logic rst, input logic v, input logic [31:0] pc,
                      input logic [31:0] tgt, input logic tk, input logic hit,
                      input logic [1:0] st, input logic [31:0] ptgt, input logic busy);
    Rst_n = rst; ExValid = v; ExPC = pc; ExTarget = tgt; ExTaken = tk;
    ExHit = hit; ExState = st; ExPredTarget = ptgt; BtbBusy = busy;
    #1;
    model_check();
    model_update();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic idle(input logic busy);
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 32'd0, busy);
  endtask

  initial begin
    m_last  = '{pc: 32'd0, tgt: 32'd0, st: 2'd0};
    m_flush = 1'b0;
    m_redir = 32'd0;

    // Reset for two cycles, with a branch presented that must be dropped.
    step(1'b0, 1'b1, 32'h44, 32'h444, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
    chk_en = 1'b1;
    step(1'b0, 1'b1, 32'h44, 32'h444, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
    cmp("rst_we", 32'(we), 32'd0);
    cmp("rst_flush", 32'(Flush), 32'd0);
    cmp("rst_redirect", RedirectPC, 32'd0);
    cmp("rst_addr2", Address2, 32'd0);
    cmp("rst_fsm", 32'(FSMResult), 32'd0);
    cmp("rst_ready", 32'(ExReady), 32'd1);

    // Allocate: miss, taken.
    step(1'b1, 1'b1, 32'h40, 32'h100, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
    cmp("alloc_flush", 32'(Flush), 32'd1);
    cmp("alloc_redirect", RedirectPC, 32'h100);
    cmp("alloc_we", 32'(we), 32'd1);
    cmp("alloc_addr2", Address2, 32'h40);
    cmp("alloc_baddr", BranchAddress, 32'h100);
    cmp("alloc_fsm", 32'(FSMResult), 32'd2);

    // Saturation at both ends.
    step(1'b1, 1'b1, 32'h60, 32'h600, 1'b1, 1'b1, 2'd3, 32'h600, 1'b0);
    cmp("sat_hi_flush", 32'(Flush), 32'd0);
    cmp("sat_hi_addr2", Address2, 32'h60);
    cmp("sat_hi_fsm", 32'(FSMResult), 32'd3);
    step(1'b1, 1'b1, 32'h70, 32'h700, 1'b0, 1'b1, 2'd0, 32'h700, 1'b0);
    cmp("sat_lo_flush", 32'(Flush), 32'd0);
    cmp("sat_lo_addr2", Address2, 32'h70);
    cmp("sat_lo_fsm", 32'(FSMResult), 32'd0);
    idle(1'b0);
    cmp("drain_we", 32'(we), 32'd0);

    // Forwarding from the queue while the write port is busy.
    step(1'b1, 1'b1, 32'h80, 32'h180, 1'b1, 1'b1, 2'd1, 32'h180, 1'b1);
    cmp("fwd1_flush", 32'(Flush), 32'd1);
    cmp("fwd1_redirect", RedirectPC, 32'h180);
    cmp("fwd1_fsm", 32'(FSMResult), 32'd2);
    step(1'b1, 1'b1, 32'h80, 32'h180, 1'b1, 1'b1, 2'd1, 32'h180, 1'b1);
    cmp("fwd2_flush", 32'(Flush), 32'd1);
    cmp("fwd2_we", 32'(we), 32'd0);
    idle(1'b0);
    cmp("fwd_pop_we", 32'(we), 32'd1);
    cmp("fwd_pop_fsm", 32'(FSMResult), 32'd3);
    idle(1'b0);
    cmp("fwd_hold_we", 32'(we), 32'd0);
    cmp("fwd_hold_fsm", 32'(FSMResult), 32'd3);

    // Fill the queue, offer a fifth branch, then drain in order.
    for (int k = 0; k < DEPTH; k++)
      step(1'b1, 1'b1, 32'h90 + 32'(4*k), 32'h900 + 32'(k), 1'b1, 1'b0, 2'd0, 32'd0, 1'b1);
    cmp("full_ready", 32'(ExReady), 32'd0);
    step(1'b1, 1'b1, 32'hA0, 32'hA00, 1'b1, 1'b0, 2'd0, 32'd0, 1'b1);
    cmp("full_reject_ready", 32'(ExReady), 32'd0);
    cmp("full_reject_flush", 32'(Flush), 32'd0);
    for (int k = 0; k < DEPTH; k++) begin
      idle(1'b0);
      if (k < DEPTH - 1) begin
        cmp("drain_ready", 32'(ExReady), 32'd1);
        cmp("drain_order", Address2, 32'h90 + 32'(4*(k+1)));
      end else begin
        cmp("drain_last_we", 32'(we), 32'd0);
        cmp("drain_last_addr2", Address2, 32'h9C);
      end
    end

    // Target mismatch, then miss not-taken.
    step(1'b1, 1'b1, 32'hB0, 32'h300, 1'b1, 1'b1, 2'd2, 32'h200, 1'b0);
    cmp("tmis_flush", 32'(Flush), 32'd1);
    cmp("tmis_redirect", RedirectPC, 32'h300);
    step(1'b1, 1'b1, 32'h50, 32'h5000, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
    cmp("nt_miss_flush", 32'(Flush), 32'd0);
    cmp("nt_miss_we", 32'(we), 32'd0);
    cmp("nt_miss_addr2", Address2, 32'hB0);

    // Reset in the middle of a drain.
    for (int k = 0; k < 3; k++)
      step(1'b1, 1'b1, 32'hC0 + 32'(4*k), 32'hC00, 1'b1, 1'b0, 2'd0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
    cmp("rstmid_we", 32'(we), 32'd0);
    cmp("rstmid_ready", 32'(ExReady), 32'd1);
    cmp("rstmid_addr2", Address2, 32'd0);
    idle(1'b0);
    cmp("rstmid_after_we", 32'(we), 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] pc, tgt, ptgt;
      pc   = 32'h1000 + 32'(4 * $urandom_range(0, 3));
      tgt  = 32'h2000 + 32'(4 * $urandom_range(0, 3));
      ptgt = ($urandom_range(0, 1) == 0) ? tgt : 32'h2000 + 32'(4 * $urandom_range(0, 3));
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), pc, tgt,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           ptgt, ($urandom_range(0, 2) == 0));
    end
    idle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
